id_ex_operand_stage: RTL

//  ID/EX pipeline register plus EX-stage operand selection for the 5-stage MIPS core.

---
 rtl/id_ex_operand_stage.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, stall refresh and flush.
// Define ID_EX_FWD_EN to build the EX/MEM and MEM/WB forwarding paths; without it operands come raw from the register.
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc,
  input  logic [CW-1:0] id_alu_ctrl,
  input  logic [RW-1:0] id_wa,
  input  logic          id_regwrite,
  input  logic [RW-1:0] mem_wa,
  input  logic          mem_regwrite,
  input  logic [DW-1:0] mem_wd,
  input  logic [RW-1:0] wb_wa,
  input  logic          wb_regwrite,
  input  logic [DW-1:0] wb_wd,
  output logic [DW-1:0] ex_A,
  output logic [DW-1:0] ex_B,
  output logic [DW-1:0] ex_rt_fwd,
  output logic [CW-1:0] ex_alu_ctrl,
  output logic [RW-1:0] ex_wa,
  output logic          ex_regwrite,
  output logic          ex_valid
);

  logic          valid_q,    valid_d;
  logic [RW-1:0] rs_q,       rs_d;
  logic [RW-1:0] rt_q,       rt_d;
  logic [DW-1:0] rs_val_q,   rs_val_d;
  logic [DW-1:0] rt_val_q,   rt_val_d;
  logic [DW-1:0] imm_q,      imm_d;
  logic          alusrc_q,   alusrc_d;
  logic [CW-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [RW-1:0] wa_q,       wa_d;
  logic          regwrite_q, regwrite_d;
  logic [DW-1:0] fwd_rs,     fwd_rt;

`ifdef ID_EX_FWD_EN
  // A producer matches a source only if it writes, targets it, and the source is not $0.
  function automatic logic src_hit(input logic we, input logic [RW-1:0] wa,
                                   input logic [RW-1:0] src);
    return we && (wa == src) && (src != '0);
  endfunction
`endif

  // NOTE: every _d gets a default (hold) first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d    = valid_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rs_val_d   = rs_val_q;
    rt_val_d   = rt_val_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    alu_ctrl_d = alu_ctrl_q;
    wa_d       = wa_q;
    regwrite_d = regwrite_q;
    if (flush) begin
      valid_d    = 1'b0;
      rs_d       = '0;
      rt_d       = '0;
      rs_val_d   = '0;
      rt_val_d   = '0;
      imm_d      = '0;
      alusrc_d   = 1'b0;
      alu_ctrl_d = '0;
      wa_d       = '0;
      regwrite_d = 1'b0;
    end else if (stall) begin
`ifdef ID_EX_FWD_EN
      // WB may retire a held operand's producer while we wait.
      if (src_hit(wb_regwrite, wb_wa, rs_q)) rs_val_d = wb_wd;
      if (src_hit(wb_regwrite, wb_wa, rt_q)) rt_val_d = wb_wd;
`endif
    end else begin
      valid_d    = id_valid;
      rs_d       = id_rs;
      rt_d       = id_rt;
      rs_val_d   = id_rs_val;
      rt_val_d   = id_rt_val;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      alu_ctrl_d = id_alu_ctrl;
      wa_d       = id_wa;
      regwrite_d = id_regwrite;
`ifdef ID_EX_FWD_EN
      if (src_hit(wb_regwrite, wb_wa, id_rs)) rs_val_d = wb_wd;
      if (src_hit(wb_regwrite, wb_wa, id_rt)) rt_val_d = wb_wd;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      alu_ctrl_q <= '0;
      wa_q       <= '0;
      regwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      alu_ctrl_q <= alu_ctrl_d;
      wa_q       <= wa_d;
      regwrite_q <= regwrite_d;
    end
  end

`ifdef ID_EX_FWD_EN
  // MEM is the younger producer, so it takes priority over WB.
  always_comb begin
    fwd_rs = rs_val_q;
    fwd_rt = rt_val_q;
    if (src_hit(mem_regwrite, mem_wa, rs_q))     fwd_rs = mem_wd;
    else if (src_hit(wb_regwrite, wb_wa, rs_q))  fwd_rs = wb_wd;
    if (src_hit(mem_regwrite, mem_wa, rt_q))     fwd_rt = mem_wd;
    else if (src_hit(wb_regwrite, wb_wa, rt_q))  fwd_rt = wb_wd;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_wa, mem_regwrite, mem_wd, wb_wa, wb_regwrite, wb_wd,
                               rs_q, rt_q};
  always_comb begin
    fwd_rs = rs_val_q;
    fwd_rt = rt_val_q;
  end
`endif

  assign ex_A        = fwd_rs;
  assign ex_rt_fwd   = fwd_rt;
  assign ex_B        = alusrc_q ? imm_q : fwd_rt;
  assign ex_alu_ctrl = alu_ctrl_q;
  assign ex_wa       = wa_q;
  assign ex_regwrite = regwrite_q;
  assign ex_valid    = valid_q;

endmodule
